// File: rtl/alu_exe_mem_stage_if.sv
// Interface bundle for alu_exe_mem_stage: the execute-stage inputs, the
// combinational ALU outputs, and the registered copies handed to the memory
// stage. The master modport drives the execute inputs. The slave modport is
// the stage itself.
interface alu_exe_mem_stage_if;

  // Instruction fields and operands
  logic [5:0]  opCode;
  logic [5:0]  funct;
  logic [31:0] oprd1;
  logic [31:0] oprd2;
  logic [4:0]  shamt;

  // Values and control carried along to later stages
  logic [31:0] regData2_E;
  logic [4:0]  writeReg_E;
  logic        regWrite_E;
  logic        memToReg_E;
  logic        memWrite_E;
  logic        memRead_E;
  logic        loadFullWord_E;
  logic        loadSigned_E;

  // Pipeline-register enable (1 = load, 0 = hold)
  logic        write;

  // Combinational ALU outputs
  logic [3:0]  aluOp;
  logic [31:0] aluResult;
  logic        aluZero;
  logic        overflow;

  // Registered execute/memory pipeline outputs
  logic [31:0] aluResult_M;
  logic [31:0] regData2_M;
  logic [4:0]  writeReg_M;
  logic        regWrite_M;
  logic        memToReg_M;
  logic        memWrite_M;
  logic        memRead_M;
  logic        loadFullWord_M;
  logic        loadSigned_M;
  logic        overflow_M;

  modport master (
    output opCode, funct, oprd1, oprd2, shamt,
    output regData2_E, writeReg_E,
    output regWrite_E, memToReg_E, memWrite_E, memRead_E,
    output loadFullWord_E, loadSigned_E,
    output write,
    input  aluOp, aluResult, aluZero, overflow,
    input  aluResult_M, regData2_M, writeReg_M,
    input  regWrite_M, memToReg_M, memWrite_M, memRead_M,
    input  loadFullWord_M, loadSigned_M, overflow_M
  );

  modport slave (
    input  opCode, funct, oprd1, oprd2, shamt,
    input  regData2_E, writeReg_E,
    input  regWrite_E, memToReg_E, memWrite_E, memRead_E,
    input  loadFullWord_E, loadSigned_E,
    input  write,
    output aluOp, aluResult, aluZero, overflow,
    output aluResult_M, regData2_M, writeReg_M,
    output regWrite_M, memToReg_M, memWrite_M, memRead_M,
    output loadFullWord_M, loadSigned_M, overflow_M
  );

endinterface

// File: rtl/alu_exe_mem_stage.sv
// Execute stage of a MIPS-style pipeline. It contains the ALU op decoder, the
// 32-bit ALU, and the EX/MEM pipeline register.
// The optional macro ALU_OVERFLOW_EN builds signed-overflow detection for
// ADD and SUB. Without it, overflow and overflow_M are tied to 0.
module alu_exe_mem_stage (
  input  logic                 clk,
  input  logic                 reset,
  alu_exe_mem_stage_if.slave   bus
);

  typedef enum logic [3:0] {
    OP_AND  = 4'd0,
    OP_OR   = 4'd1,
    OP_ADD  = 4'd2,
    OP_XOR  = 4'd3,
    OP_NOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SUB  = 4'd6,
    OP_SLT  = 4'd7,
    OP_SLTU = 4'd8,
    OP_SRL  = 4'd9,
    OP_SRA  = 4'd10,
    OP_LUI  = 4'd11
  } aluOp_e;

  aluOp_e      aluOpDec;
  logic [31:0] aluResultC;
  logic        overflowC;

  // Decode opCode/funct into the 4-bit ALU operation
  always_comb begin
    // NOTE: assign a default first so every path through the case
    // statements drives the signal. This keeps the block free of latches.
    aluOpDec = OP_ADD;
    if (bus.opCode == 6'h00) begin
      unique case (bus.funct)
        6'h20, 6'h21: aluOpDec = OP_ADD;
        6'h22, 6'h23: aluOpDec = OP_SUB;
        6'h24:        aluOpDec = OP_AND;
        6'h25:        aluOpDec = OP_OR;
        6'h26:        aluOpDec = OP_XOR;
        6'h27:        aluOpDec = OP_NOR;
        6'h2A:        aluOpDec = OP_SLT;
        6'h2B:        aluOpDec = OP_SLTU;
        6'h00:        aluOpDec = OP_SLL;
        6'h02:        aluOpDec = OP_SRL;
        6'h03:        aluOpDec = OP_SRA;
        default:      aluOpDec = OP_ADD;
      endcase
    end else begin
      unique case (bus.opCode)
        6'h08, 6'h09: aluOpDec = OP_ADD;
        6'h0C:        aluOpDec = OP_AND;
        6'h0D:        aluOpDec = OP_OR;
        6'h0E:        aluOpDec = OP_XOR;
        6'h0A:        aluOpDec = OP_SLT;
        6'h0B:        aluOpDec = OP_SLTU;
        6'h0F:        aluOpDec = OP_LUI;
        6'h04, 6'h05: aluOpDec = OP_SUB;
        // Loads and stores compute base + offset
        6'h20, 6'h23, 6'h24, 6'h25,
        6'h28, 6'h29, 6'h2B:
                      aluOpDec = OP_ADD;
        default:      aluOpDec = OP_ADD;
      endcase
    end
  end

  // ALU datapath. Shifts act on oprd2, and op codes 12-15 produce 0.
  always_comb begin
    aluResultC = 32'd0;
    unique case (aluOpDec)
      OP_AND:  aluResultC = bus.oprd1 & bus.oprd2;
      OP_OR:   aluResultC = bus.oprd1 | bus.oprd2;
      OP_ADD:  aluResultC = bus.oprd1 + bus.oprd2;
      OP_XOR:  aluResultC = bus.oprd1 ^ bus.oprd2;
      OP_NOR:  aluResultC = ~(bus.oprd1 | bus.oprd2);
      OP_SLL:  aluResultC = bus.oprd2 << bus.shamt;
      OP_SUB:  aluResultC = bus.oprd1 - bus.oprd2;
      OP_SLT:  aluResultC = {31'd0, $signed(bus.oprd1) < $signed(bus.oprd2)};
      OP_SLTU: aluResultC = {31'd0, bus.oprd1 < bus.oprd2};
      OP_SRL:  aluResultC = bus.oprd2 >> bus.shamt;
      OP_SRA:  aluResultC = $unsigned($signed(bus.oprd2) >>> bus.shamt);
      OP_LUI:  aluResultC = {bus.oprd2[15:0], 16'd0};
      default: aluResultC = 32'd0;
    endcase
  end

`ifdef ALU_OVERFLOW_EN
  // Signed overflow: an ADD whose operands share a sign, or a SUB whose
  // operands differ in sign, overflows when the result sign differs from oprd1
  always_comb begin
    overflowC = 1'b0;
    if (aluOpDec == OP_ADD)
      overflowC = (bus.oprd1[31] == bus.oprd2[31]) &&
                  (aluResultC[31] != bus.oprd1[31]);
    else if (aluOpDec == OP_SUB)
      overflowC = (bus.oprd1[31] != bus.oprd2[31]) &&
                  (aluResultC[31] != bus.oprd1[31]);
  end
`else
  assign overflowC = 1'b0;
`endif

  assign bus.aluOp     = aluOpDec;
  assign bus.aluResult = aluResultC;
  assign bus.aluZero   = (aluResultC == 32'd0);
  assign bus.overflow  = overflowC;

  // EX/MEM pipeline register: clear on reset, load when write=1, otherwise hold
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: registered state uses non-blocking assignments so every
    // register samples its inputs before any register updates.
    if (reset) begin
      bus.aluResult_M    <= 32'd0;
      bus.regData2_M     <= 32'd0;
      bus.writeReg_M     <= 5'd0;
      bus.regWrite_M     <= 1'b0;
      bus.memToReg_M     <= 1'b0;
      bus.memWrite_M     <= 1'b0;
      bus.memRead_M      <= 1'b0;
      bus.loadFullWord_M <= 1'b0;
      bus.loadSigned_M   <= 1'b0;
    end else if (bus.write) begin
      bus.aluResult_M    <= aluResultC;
      bus.regData2_M     <= bus.regData2_E;
      bus.writeReg_M     <= bus.writeReg_E;
      bus.regWrite_M     <= bus.regWrite_E;
      bus.memToReg_M     <= bus.memToReg_E;
      bus.memWrite_M     <= bus.memWrite_E;
      bus.memRead_M      <= bus.memRead_E;
      bus.loadFullWord_M <= bus.loadFullWord_E;
      bus.loadSigned_M   <= bus.loadSigned_E;
    end
  end

`ifdef ALU_OVERFLOW_EN
  // Registered overflow flag follows the same reset/enable rules
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      bus.overflow_M <= 1'b0;
    else if (bus.write)
      bus.overflow_M <= overflowC;
  end
`else
  assign bus.overflow_M = 1'b0;
`endif

endmodule

// File: tb/tb_alu_exe_mem_stage.sv
// Self-checking bench for alu_exe_mem_stage. The stimulus is a table of ALU
// vectors whose expected op codes and results are written out by hand. The
// registered outputs are checked against a scoreboard queue: each expected
// value is pushed when the bench drives stimulus and popped after the next
// rising edge.
module tb_alu_exe_mem_stage;

  localparam bit OvfEn =
`ifdef ALU_OVERFLOW_EN
    1'b1;
`else
    1'b0;
`endif

  typedef struct {
    logic [5:0]  opCode;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic [3:0]  eOp;
    logic [31:0] eRes;
    logic        eOvf;
  } vec_t;

  typedef struct packed {
    logic [31:0] aluResult;
    logic [31:0] regData2;
    logic [4:0]  writeReg;
    logic [5:0]  ctrl;   // regWrite, memToReg, memWrite, memRead, loadFullWord, loadSigned
    logic        overflow;
  } mexp_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  vec_t  vecs[$];
  mexp_t sbq[$];
  mexp_t lastM;

  alu_exe_mem_stage_if bus ();

  alu_exe_mem_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1);
  end

  function automatic mexp_t actual_m();
    mexp_t m;
    m.aluResult = bus.aluResult_M;
    m.regData2  = bus.regData2_M;
    m.writeReg  = bus.writeReg_M;
    m.ctrl      = {bus.regWrite_M, bus.memToReg_M, bus.memWrite_M,
                   bus.memRead_M, bus.loadFullWord_M, bus.loadSigned_M};
    m.overflow  = bus.overflow_M;
    return m;
  endfunction

  task automatic add_vec(input logic [5:0] op, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic [3:0] eOp,
                         input logic [31:0] eRes, input logic eOvf);
    vec_t v;
    v.opCode = op; v.funct = f; v.a = a; v.b = b; v.shamt = sh;
    v.eOp = eOp; v.eRes = eRes; v.eOvf = eOvf;
    vecs.push_back(v);
  endtask

  task automatic build_table();
    add_vec(6'h08, 6'h00, 32'd0,        32'd5,        5'd0,  4'd2,  32'd5,        1'b0); // 0 ADDI
    add_vec(6'h04, 6'h00, 32'd5,        32'd0,        5'd0,  4'd6,  32'd5,        1'b0); // 1 BEQ sub
    add_vec(6'h04, 6'h00, 32'd0,        32'd0,        5'd0,  4'd6,  32'd0,        1'b0); // 2 BEQ zero
    add_vec(6'h00, 6'h02, 32'd0,        32'd5,        5'd1,  4'd9,  32'd2,        1'b0); // 3 SRL
    add_vec(6'h00, 6'h03, 32'd0,        32'h80000000, 5'd4,  4'd10, 32'hF8000000, 1'b0); // 4 SRA
    add_vec(6'h00, 6'h20, 32'h7FFFFFFF, 32'd1,        5'd0,  4'd2,  32'h80000000, 1'b1); // 5 ADD ovf
    add_vec(6'h00, 6'h24, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0,  4'd0,  32'h00F000F0, 1'b0); // 6 AND
    add_vec(6'h00, 6'h25, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0,  4'd1,  32'hFFF0FFF0, 1'b0); // 7 OR
    add_vec(6'h00, 6'h26, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0,  4'd3,  32'hFF00FF00, 1'b0); // 8 XOR
    add_vec(6'h00, 6'h27, 32'd0,        32'd0,        5'd0,  4'd4,  32'hFFFFFFFF, 1'b0); // 9 NOR
    add_vec(6'h00, 6'h2A, 32'hFFFFFFFF, 32'd1,        5'd0,  4'd7,  32'd1,        1'b0); // 10 SLT
    add_vec(6'h00, 6'h2B, 32'hFFFFFFFF, 32'd1,        5'd0,  4'd8,  32'd0,        1'b0); // 11 SLTU
    add_vec(6'h00, 6'h00, 32'hAAAAAAAA, 32'd1,        5'd31, 4'd5,  32'h80000000, 1'b0); // 12 SLL
    add_vec(6'h00, 6'h03, 32'd0,        32'h80000000, 5'd0,  4'd10, 32'h80000000, 1'b0); // 13 SRA by 0
    add_vec(6'h00, 6'h02, 32'd0,        32'h80000000, 5'd31, 4'd9,  32'd1,        1'b0); // 14 SRL by 31
    add_vec(6'h0F, 6'h00, 32'h55555555, 32'h00001234, 5'd0,  4'd11, 32'h12340000, 1'b0); // 15 LUI
    add_vec(6'h0A, 6'h00, 32'd5,        32'd7,        5'd0,  4'd7,  32'd1,        1'b0); // 16 SLTI
    add_vec(6'h0B, 6'h00, 32'h80000000, 32'd1,        5'd0,  4'd8,  32'd0,        1'b0); // 17 SLTIU
    add_vec(6'h23, 6'h00, 32'h00000100, 32'd4,        5'd0,  4'd2,  32'h00000104, 1'b0); // 18 LW
    add_vec(6'h05, 6'h00, 32'h80000000, 32'd1,        5'd0,  4'd6,  32'h7FFFFFFF, 1'b1); // 19 BNE ovf
    add_vec(6'h3F, 6'h00, 32'd3,        32'd4,        5'd0,  4'd2,  32'd7,        1'b0); // 20 unknown op
    add_vec(6'h00, 6'h3F, 32'hFFFFFFFF, 32'd1,        5'd0,  4'd2,  32'd0,        1'b0); // 21 unknown funct
    add_vec(6'h0C, 6'h00, 32'h000000FF, 32'h0000000F, 5'd0,  4'd0,  32'h0000000F, 1'b0); // 22 ANDI
    add_vec(6'h0D, 6'h00, 32'h000000F0, 32'h0000000F, 5'd0,  4'd1,  32'h000000FF, 1'b0); // 23 ORI
    add_vec(6'h0E, 6'h00, 32'h000000FF, 32'h0000000F, 5'd0,  4'd3,  32'h000000F0, 1'b0); // 24 XORI
    add_vec(6'h09, 6'h00, 32'd1,        32'd1,        5'd0,  4'd2,  32'd2,        1'b0); // 25 ADDIU
    add_vec(6'h00, 6'h21, 32'h80000000, 32'h80000000, 5'd0,  4'd2,  32'd0,        1'b1); // 26 ADDU wrap
    add_vec(6'h00, 6'h23, 32'd0,        32'd1,        5'd0,  4'd6,  32'hFFFFFFFF, 1'b0); // 27 SUBU
    add_vec(6'h2B, 6'h00, 32'hFFFFFFFC, 32'd4,        5'd0,  4'd2,  32'd0,        1'b0); // 28 SW wrap
  endtask

  // Drive one vector at the falling edge, check the combinational outputs,
  // then check the registered outputs just after the next rising edge.
  task automatic run_vec(input int idx, input logic wr, input logic [31:0] rd2,
                         input logic [4:0] wreg, input logic [5:0] ctrl);
    vec_t  v;
    mexp_t e;
    mexp_t act;
    logic  eZero;
    v = vecs[idx];
    @(negedge clk);
    bus.opCode = v.opCode;  bus.funct = v.funct;
    bus.oprd1  = v.a;       bus.oprd2 = v.b;     bus.shamt = v.shamt;
    bus.regData2_E = rd2;   bus.writeReg_E = wreg;
    {bus.regWrite_E, bus.memToReg_E, bus.memWrite_E, bus.memRead_E,
     bus.loadFullWord_E, bus.loadSigned_E} = ctrl;
    bus.write = wr;
    #1;
    eZero = (v.eRes == 32'd0);
    checks++;
    if ({bus.aluOp, bus.aluResult, bus.aluZero, bus.overflow} !==
        {v.eOp, v.eRes, eZero, v.eOvf & OvfEn}) begin
      failures++;
      $display("FAIL comb[%0d]: got op=%0d res=%h zero=%b ovf=%b, want op=%0d res=%h zero=%b ovf=%b",
               idx, bus.aluOp, bus.aluResult, bus.aluZero, bus.overflow,
               v.eOp, v.eRes, eZero, v.eOvf & OvfEn);
    end
    if (wr) begin
      e.aluResult = v.eRes; e.regData2 = rd2; e.writeReg = wreg;
      e.ctrl = ctrl;        e.overflow = v.eOvf & OvfEn;
      lastM = e;
    end
    sbq.push_back(lastM);
    @(posedge clk);
    #1;
    checks++;
    if (sbq.size() == 0) begin
      failures++;
      $display("FAIL regs[%0d]: scoreboard empty", idx);
    end else begin
      e   = sbq.pop_front();
      act = actual_m();
      if (act !== e) begin
        failures++;
        $display("FAIL regs[%0d] wr=%b: got res=%h rd2=%h wreg=%0d ctrl=%b ovf=%b, want res=%h rd2=%h wreg=%0d ctrl=%b ovf=%b",
                 idx, wr, act.aluResult, act.regData2, act.writeReg, act.ctrl, act.overflow,
                 e.aluResult, e.regData2, e.writeReg, e.ctrl, e.overflow);
      end
    end
  endtask

  task automatic run_rand(input int idx, input logic wr);
    run_vec(idx, wr, $urandom, 5'($urandom_range(0, 31)), 6'($urandom_range(0, 63)));
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.opCode = 6'h08; bus.funct = 6'h00; bus.oprd1 = 32'd9; bus.oprd2 = 32'd9;
    bus.shamt = 5'd0; bus.regData2_E = 32'hFFFFFFFF; bus.writeReg_E = 5'd31;
    {bus.regWrite_E, bus.memToReg_E, bus.memWrite_E, bus.memRead_E,
     bus.loadFullWord_E, bus.loadSigned_E} = 6'b111111;
    bus.write = 1'b1;
    #1;
    checks++;
    if (actual_m() !== '0) begin
      failures++;
      $display("FAIL reset_initial: got %h want 0", actual_m());
    end
    // Rising edges under reset must not load, even with write=1
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (actual_m() !== '0) begin
      failures++;
      $display("FAIL reset_edges: got %h want 0", actual_m());
    end
    @(negedge clk);
    reset = 1'b0;
    lastM = '0;
  endtask

  task automatic test_add_imm();
    run_rand(0, 1'b1);
  endtask

  task automatic test_sub_zero();
    run_rand(1, 1'b1);
    run_rand(2, 1'b1);
  endtask

  task automatic test_shifts();
    run_rand(3, 1'b1);
    run_rand(4, 1'b1);
    run_rand(12, 1'b1);
    run_rand(13, 1'b1);
    run_rand(14, 1'b1);
  endtask

  task automatic test_overflow();
    run_rand(5, 1'b1);
    run_rand(19, 1'b1);
    run_rand(26, 1'b1);
    run_rand(27, 1'b1);
  endtask

  task automatic test_decode();
    for (int i = 6; i < vecs.size(); i++) run_rand(i, 1'b1);
  endtask

  task automatic test_hold_reset();
    run_vec(0, 1'b1, 32'hDEADBEEF, 5'd19, 6'b100000);
    run_vec(6, 1'b0, 32'h12345678, 5'd7,  6'b011111);
    run_vec(9, 1'b0, 32'hCAFEF00D, 5'd3,  6'b010101);
    // Assert reset partway between edges: outputs clear without a clock edge
    @(negedge clk);
    #2;
    bus.write = 1'b1;
    reset = 1'b1;
    #1;
    checks++;
    if (actual_m() !== '0) begin
      failures++;
      $display("FAIL reset_async: got %h want 0", actual_m());
    end
    checks++;
    if ({bus.aluResult, bus.aluOp} !== {vecs[9].eRes, vecs[9].eOp}) begin
      failures++;
      $display("FAIL reset_comb: got res=%h op=%0d want res=%h op=%0d",
               bus.aluResult, bus.aluOp, vecs[9].eRes, vecs[9].eOp);
    end
    @(posedge clk);
    #1;
    checks++;
    if (actual_m() !== '0) begin
      failures++;
      $display("FAIL reset_hold: got %h want 0", actual_m());
    end
    @(negedge clk);
    reset = 1'b0;
    lastM = '0;
    // The first edge after release with write=1 loads
    run_rand(15, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < vecs.size(); i++) run_rand(i, 1'b1);
    for (int i = 0; i < 4; i++) run_rand(i + 20, 1'(i[0]));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    lastM    = '0;
    build_table();
    test_reset();
    test_add_imm();
    test_sub_zero();
    test_shifts();
    test_overflow();
    test_decode();
    test_hold_reset();
    test_back_to_back();
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_exe_mem_stage.md
ALU_EXE_MEM_STAGE -- requirements
Module: alu_exe_mem_stage

Interface
REQ-001 Parameters: none; data width fixed at 32 bits, shift amount 5 bits, ALU op code 4 bits.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high; clears all pipeline outputs.
REQ-004 opCode  in  6  instruction bits [31:26]; funct  in  6  instruction bits [5:0].
REQ-005 oprd1  in  32  ALU operand A (rs data); oprd2  in  32  ALU operand B (rt data or extended immediate).
REQ-006 shamt  in  5  shift amount; regData2_E  in  32  store data; writeReg_E  in  5  destination register.
REQ-007 regWrite_E, memToReg_E, memWrite_E, memRead_E, loadFullWord_E, loadSigned_E  in  1 each  control bits for later stages.
REQ-008 write  in  1  pipeline-register enable; 1 = load, 0 = hold.
REQ-009 aluOp  out  4  decoded op code; aluResult  out  32; aluZero  out  1; overflow  out  1 (all combinational).
REQ-010 aluResult_M, regData2_M (32), writeReg_M (5), the six control bits with _M suffix, overflow_M  out  registered copies.

Function
REQ-011 Decode for opCode 0x00 by funct: 0x20/0x21 ADD, 0x22/0x23 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SLT, 0x2B SLTU, 0x00 SLL, 0x02 SRL, 0x03 SRA; any other funct ADD.
REQ-012 Decode for other opCodes: 0x08/0x09 ADD, 0x0C AND, 0x0D OR, 0x0E XOR, 0x0A SLT, 0x0B SLTU, 0x0F LUI, 0x04/0x05 SUB, loads/stores 0x20,0x23,0x24,0x25,0x28,0x29,0x2B ADD; any other opCode ADD.
REQ-013 Op codes: 0 AND, 1 OR, 2 ADD, 3 XOR, 4 NOR, 5 SLL, 6 SUB, 7 SLT, 8 SLTU, 9 SRL, 10 SRA, 11 LUI, 12-15 result 0.
REQ-014 ADD/SUB modulo 2^32; SLT signed and SLTU unsigned compare of oprd1 vs oprd2, result 1 or 0 zero-extended.
REQ-015 SLL/SRL/SRA shift oprd2 by shamt (oprd1 ignored); SRA replicates bit 31; shamt 0 passes oprd2 unchanged.
REQ-016 LUI result = oprd2[15:0] followed by 16 zero bits.
REQ-017 aluZero = 1 exactly when aluResult is all zeros, for every op code.
REQ-018 Combinational path opCode/funct -> aluOp -> aluResult/aluZero settles within the same cycle; no latches.
REQ-019 On rising clk with write=1 and reset=0, every _M output takes its corresponding current input/ALU value (one-cycle latency).
REQ-020 With write=0, all _M outputs hold; combinational outputs still track inputs.

Reset
REQ-021 reset=1 forces every _M output to 0 immediately, independent of clk and write.
REQ-022 While reset=1, rising edges load nothing; first load occurs on the first rising edge after reset deasserts with write=1.
REQ-023 Combinational outputs are unaffected by reset.

Configuration
REQ-024 Macro ALU_OVERFLOW_EN: when defined, overflow = signed overflow of ADD (operands same sign, result differs) or SUB (operands differ in sign, result sign differs from oprd1), else 0; overflow_M registers it like other _M outputs.
REQ-025 Without ALU_OVERFLOW_EN, overflow and overflow_M are constant 0 and no overflow logic is built.

Verification
REQ-026 opCode 0x08, oprd1 0, oprd2 5, write 1 -> aluOp 2, aluResult 5, aluZero 0; after edge aluResult_M 5.
REQ-027 opCode 0x04: oprd1 5, oprd2 0 -> aluResult 5, aluZero 0; oprd1 0, oprd2 0 -> aluResult 0, aluZero 1.
REQ-028 opCode 0x00 funct 0x02, oprd2 5, shamt 1 -> aluOp 9, aluResult 2; funct 0x03, oprd2 0x80000000, shamt 4 -> 0xF8000000.
REQ-029 Load regData2_E 0xDEADBEEF, writeReg_E 19, regWrite_E 1; then write 0 with new inputs -> _M holds 0xDEADBEEF/19/1; assert reset between edges -> all _M 0 at once.
REQ-030 opCode 0x00 funct 0x20, oprd1 0x7FFFFFFF, oprd2 1 -> aluResult 0x80000000; overflow 1 with ALU_OVERFLOW_EN, 0 without.
